// File: rtl/packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : packet_receiver
//  Description : Demultiplexes BCH-corrected data island packets into an
//                8-entry stereo audio FIFO, ACR N/CTS and AVI VIC registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_receiver #(
    parameter int AUDIO_BIT_WIDTH = 16
) (
    input  logic                       clk_pixel,
    input  logic                       reset,
    input  logic                       packet_valid,
    input  logic                       packet_error,
    input  logic [23:0]                header,
    input  logic [223:0]               sub,
    input  logic                       audio_ready,
    output logic                       audio_valid,
    output logic [AUDIO_BIT_WIDTH-1:0] audio_left,
    output logic [AUDIO_BIT_WIDTH-1:0] audio_right,
    output logic                       audio_block_start,
    output logic                       audio_overflow,
    output logic                       acr_valid,
    output logic [19:0]                acr_n,
    output logic [19:0]                acr_cts,
    output logic [6:0]                 avi_vic,
    output logic                       infoframe_checksum_error
);

    localparam logic [7:0] c_TYPE_ACR    = 8'h01;
    localparam logic [7:0] c_TYPE_AUDIO  = 8'h02;
    localparam logic [7:0] c_TYPE_AVI    = 8'h82;
    localparam logic [7:0] c_TYPE_SPD    = 8'h83;
    localparam logic [7:0] c_TYPE_AUD_IF = 8'h84;

    logic [AUDIO_BIT_WIDTH-1:0] r_mem_left  [0:7];
    logic [AUDIO_BIT_WIDTH-1:0] r_mem_right [0:7];
    logic [7:0]                 r_mem_bs;
    logic [2:0]                 r_rd_ptr;
    logic [2:0]                 r_wr_ptr;
    logic [3:0]                 r_count;

    logic [AUDIO_BIT_WIDTH-1:0] w_mem_left  [0:7];
    logic [AUDIO_BIT_WIDTH-1:0] w_mem_right [0:7];
    logic [7:0]                 w_mem_bs;
    logic [2:0]                 w_wr_idx;
    logic [2:0]                 w_push_cnt;
    logic [3:0]                 w_free;
    logic [3:0]                 w_count_next;
    logic [2:0]                 w_rd_ptr_next;
    logic [7:0]                 w_sum;
    logic                       w_accept;
    logic                       w_is_audio;
    logic                       w_is_if;
    logic                       w_pop;
    logic                       w_push_ok;
    logic                       w_overflow;
    logic                       w_cs_ok;

    logic [3:0] w_present;
    logic [3:0] w_bstart;

    assign w_present  = header[11:8];
    assign w_bstart   = header[23:20];
    assign w_accept   = packet_valid & ~packet_error;
    assign w_is_audio = w_accept && (header[7:0] == c_TYPE_AUDIO);
    assign w_is_if    = w_accept && ((header[7:0] == c_TYPE_AVI) ||
                                     (header[7:0] == c_TYPE_SPD) ||
                                     (header[7:0] == c_TYPE_AUD_IF));

    assign w_push_cnt = {2'b00, w_present[0]} + {2'b00, w_present[1]} +
                        {2'b00, w_present[2]} + {2'b00, w_present[3]};
    assign w_pop      = audio_valid & audio_ready;
    // Space is judged after this cycle's pop so a full FIFO draining can still accept.
    assign w_free     = 4'd8 - r_count + {3'b000, w_pop};
    assign w_push_ok  = w_is_audio && ({1'b0, w_push_cnt} <= w_free);
    assign w_overflow = w_is_audio && ({1'b0, w_push_cnt} > w_free);

    assign w_count_next  = r_count - {3'b000, w_pop} +
                           (w_push_ok ? {1'b0, w_push_cnt} : 4'd0);
    assign w_rd_ptr_next = r_rd_ptr + {2'b00, w_pop};

    always_comb begin
        w_mem_left  = r_mem_left;
        w_mem_right = r_mem_right;
        w_mem_bs    = r_mem_bs;
        w_wr_idx    = r_wr_ptr;
        for (int j = 0; j < 4; j++) begin
            if (w_push_ok && w_present[j]) begin
                w_mem_left[w_wr_idx]  = sub[56*j+23 -: AUDIO_BIT_WIDTH];
                w_mem_right[w_wr_idx] = sub[56*j+47 -: AUDIO_BIT_WIDTH];
                w_mem_bs[w_wr_idx]    = w_bstart[j];
                w_wr_idx              = w_wr_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_sum = header[7:0] + header[15:8] + header[23:16];
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 7; k++) begin
                w_sum = w_sum + sub[56*i+8*k +: 8];
            end
        end
    end

    assign w_cs_ok = (w_sum == 8'h00);

    always_ff @(posedge clk_pixel) begin
        r_mem_left  <= w_mem_left;
        r_mem_right <= w_mem_right;
        r_mem_bs    <= w_mem_bs;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_rd_ptr                 <= 3'd0;
            r_wr_ptr                 <= 3'd0;
            r_count                  <= 4'd0;
            audio_valid              <= 1'b0;
            audio_left               <= '0;
            audio_right              <= '0;
            audio_block_start        <= 1'b0;
            audio_overflow           <= 1'b0;
            acr_valid                <= 1'b0;
            acr_n                    <= 20'd0;
            acr_cts                  <= 20'd0;
            avi_vic                  <= 7'd0;
            infoframe_checksum_error <= 1'b0;
        end else begin
            r_rd_ptr       <= w_rd_ptr_next;
            r_wr_ptr       <= w_wr_idx;
            r_count        <= w_count_next;
            audio_valid    <= (w_count_next != 4'd0);
            audio_overflow <= w_overflow;
            // Head is taken from the post-write image so an empty FIFO shows data next cycle.
            if (w_count_next != 4'd0) begin
                audio_left        <= w_mem_left[w_rd_ptr_next];
                audio_right       <= w_mem_right[w_rd_ptr_next];
                audio_block_start <= w_mem_bs[w_rd_ptr_next];
            end
            acr_valid <= w_accept && (header[7:0] == c_TYPE_ACR);
            if (w_accept && (header[7:0] == c_TYPE_ACR)) begin
                acr_cts <= {sub[11:8], sub[23:16], sub[31:24]};
                acr_n   <= {sub[35:32], sub[47:40], sub[55:48]};
            end
            infoframe_checksum_error <= w_is_if && !w_cs_ok;
            if (w_is_if && w_cs_ok && (header[7:0] == c_TYPE_AVI)) begin
                avi_vic <= sub[38:32];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_receiver
//  Description : Randomized and directed bench for packet_receiver against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_receiver;

    localparam int AW = 16;

    logic           clk_pixel = 1'b0;
    logic           reset = 1'b1;
    logic           packet_valid = 1'b0;
    logic           packet_error = 1'b0;
    logic [23:0]    header = '0;
    logic [223:0]   sub = '0;
    logic           audio_ready = 1'b0;
    logic           audio_valid;
    logic [AW-1:0]  audio_left;
    logic [AW-1:0]  audio_right;
    logic           audio_block_start;
    logic           audio_overflow;
    logic           acr_valid;
    logic [19:0]    acr_n;
    logic [19:0]    acr_cts;
    logic [6:0]     avi_vic;
    logic           infoframe_checksum_error;

    packet_receiver #(.AUDIO_BIT_WIDTH(AW)) u_dut (
        .clk_pixel                (clk_pixel),
        .reset                    (reset),
        .packet_valid             (packet_valid),
        .packet_error             (packet_error),
        .header                   (header),
        .sub                      (sub),
        .audio_ready              (audio_ready),
        .audio_valid              (audio_valid),
        .audio_left               (audio_left),
        .audio_right              (audio_right),
        .audio_block_start        (audio_block_start),
        .audio_overflow           (audio_overflow),
        .acr_valid                (acr_valid),
        .acr_n                    (acr_n),
        .acr_cts                  (acr_cts),
        .avi_vic                  (avi_vic),
        .infoframe_checksum_error (infoframe_checksum_error)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [AW-1:0] l;
        logic [AW-1:0] r;
        logic          b;
    } ent_t;

    ent_t          q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          exp_valid, exp_b, exp_ovf, exp_acr_v, exp_cse;
    logic [AW-1:0] exp_l, exp_r;
    logic [19:0]   exp_n, exp_cts;
    logic [6:0]    exp_vic;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one clock edge applied to the queue model using current inputs.
    task automatic model_edge();
        int   free;
        logic [7:0] s;
        logic [23:0] w24;
        ent_t e;
        if (reset) begin
            q.delete();
            {exp_valid, exp_b, exp_ovf, exp_acr_v, exp_cse} = '0;
            exp_l = '0; exp_r = '0; exp_n = '0; exp_cts = '0; exp_vic = '0;
            return;
        end
        exp_ovf = 0; exp_acr_v = 0; exp_cse = 0;
        if (q.size() > 0 && audio_ready) void'(q.pop_front());
        if (packet_valid && !packet_error) begin
            case (header[7:0])
                8'h02: begin
                    free = 8 - q.size();
                    if ($countones(header[11:8]) > free) exp_ovf = 1;
                    else for (int i = 0; i < 4; i++) if (header[8+i]) begin
                        w24 = sub[56*i +: 24];      e.l = w24[23 -: AW];
                        w24 = sub[56*i+24 +: 24];   e.r = w24[23 -: AW];
                        e.b = header[20+i];
                        q.push_back(e);
                    end
                end
                8'h01: begin
                    exp_acr_v = 1;
                    exp_cts = {sub[11:8], sub[23:16], sub[31:24]};
                    exp_n   = {sub[35:32], sub[47:40], sub[55:48]};
                end
                8'h82, 8'h83, 8'h84: begin
                    s = header[7:0] + header[15:8] + header[23:16];
                    for (int i = 0; i < 28; i++) s = s + sub[56*(i/7)+8*(i%7) +: 8];
                    if (s != 0) exp_cse = 1;
                    else if (header[7:0] == 8'h82) exp_vic = sub[38:32];
                end
                default: ;
            endcase
        end
        exp_valid = (q.size() > 0);
        if (exp_valid) begin
            exp_l = q[0].l; exp_r = q[0].r; exp_b = q[0].b;
        end
    endtask

    task automatic compare();
        check("valid", 32'(audio_valid), 32'(exp_valid));
        check("left", 32'(audio_left), 32'(exp_l));
        check("right", 32'(audio_right), 32'(exp_r));
        check("bstart", 32'(audio_block_start), 32'(exp_b));
        check("overflow", 32'(audio_overflow), 32'(exp_ovf));
        check("acr_valid", 32'(acr_valid), 32'(exp_acr_v));
        check("acr_n", 32'(acr_n), 32'(exp_n));
        check("acr_cts", 32'(acr_cts), 32'(exp_cts));
        check("avi_vic", 32'(avi_vic), 32'(exp_vic));
        check("cs_error", 32'(infoframe_checksum_error), 32'(exp_cse));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_pixel);
        #1;
        compare();
    endtask

    task automatic send(input logic [23:0] h, input logic [223:0] s, input logic err);
        packet_valid = 1; packet_error = err; header = h; sub = s;
        cycle();
        packet_valid = 0; packet_error = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [223:0] rand_sub();
        logic [223:0] s;
        for (int i = 0; i < 7; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    function automatic logic [223:0] make_audio(input logic [23:0] lbase, input logic [23:0] rbase);
        logic [223:0] s = '0;
        for (int i = 0; i < 4; i++) begin
            s[56*i +: 24]    = lbase + 24'(i);
            s[56*i+24 +: 24] = rbase + 24'(i);
        end
        return s;
    endfunction

    function automatic logic [223:0] make_acr(input logic [19:0] n, input logic [19:0] cts);
        logic [223:0] s = rand_sub();
        s[11:8] = cts[19:16]; s[23:16] = cts[15:8]; s[31:24] = cts[7:0];
        s[35:32] = n[19:16];  s[47:40] = n[15:8];   s[55:48] = n[7:0];
        return s;
    endfunction

    // PB0 (byte 0 of subpacket 0) is set so the whole packet sums to zero.
    function automatic logic [223:0] make_if(input logic [23:0] h, input logic [6:0] vic, input logic bad);
        logic [223:0] s = rand_sub();
        logic [7:0] sum;
        s[39:32] = {1'b0, vic};
        sum = h[7:0] + h[15:8] + h[23:16];
        for (int i = 1; i < 28; i++) sum = sum + s[56*(i/7)+8*(i%7) +: 8];
        s[7:0] = 8'h00 - sum + {7'd0, bad};
        return s;
    endfunction

    initial begin
        logic [7:0] t;
        logic [7:0] types [0:4];
        types = '{8'h00, 8'h03, 8'h81, 8'h85, 8'hFF};

        reset = 1; audio_ready = 1;
        idle(2);
        check("rst_valid", 32'(audio_valid), 32'd0);
        reset = 0;
        idle(1);

        // Four beats from a full packet, block start on the first only
        send(24'h100F02, make_audio(24'h1234A0, 24'hABCD00), 0);
        check("t1_left", 32'(audio_left), 32'h1234);
        check("t1_right", 32'(audio_right), 32'hABCD);
        check("t1_bs", 32'(audio_block_start), 32'd1);
        idle(5);

        // Sparse present mask
        send(24'h000502, make_audio(24'h111100, 24'h222200) ^ {112'd0, 56'h0000AA00AA0000, 56'd0}, 0);
        idle(4);

        // Fill to 8 with ready low, third packet overflows
        audio_ready = 0;
        send(24'h300F02, make_audio(24'h010000, 24'h020000), 0);
        send(24'hC00F02, make_audio(24'h030000, 24'h040000), 0);
        send(24'hF00F02, make_audio(24'h050000, 24'h060000), 0);
        check("t3_ovf", 32'(audio_overflow), 32'd1);
        idle(2);
        audio_ready = 1;
        idle(10);

        // ACR capture, then the same packet flagged as errored
        send(24'h000001, make_acr(20'h01800, 20'h1220A), 0);
        check("t4_n", 32'(acr_n), 32'd6144);
        check("t4_cts", 32'(acr_cts), 32'd74250);
        send(24'h000001, make_acr(20'h0ABCD, 20'h12345), 1);
        check("t4_err_n", 32'(acr_n), 32'd6144);

        // AVI VIC with good and bad checksum
        send(24'h0D0282, make_if(24'h0D0282, 7'd16, 0), 0);
        check("t5_vic", 32'(avi_vic), 32'd16);
        send(24'h0D0282, make_if(24'h0D0282, 7'd33, 1), 0);
        check("t5_cse", 32'(infoframe_checksum_error), 32'd1);
        check("t5_vic_hold", 32'(avi_vic), 32'd16);
        idle(1);

        // Reset with 5 entries queued and a packet arriving
        audio_ready = 0;
        send(24'h000F02, make_audio(24'h700000, 24'h800000), 0);
        send(24'h000102, make_audio(24'h900000, 24'hA00000), 0);
        reset = 1; audio_ready = 1;
        send(24'h000F02, make_audio(24'hB00000, 24'hC00000), 0);
        check("t6_valid", 32'(audio_valid), 32'd0);
        check("t6_left", 32'(audio_left), 32'd0);
        reset = 0;
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            audio_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) < 6) begin
                packet_valid = 1;
                packet_error = ($urandom_range(0, 9) == 0);
                sub = rand_sub();
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: header = {8'($urandom), 8'($urandom), 8'h02};
                    4, 5:       header = {16'($urandom), 8'h01};
                    6, 7, 8: begin
                        t = 8'h82 + 8'($urandom_range(0, 2));
                        header = {16'($urandom), t};
                        sub = make_if(header, 7'($urandom), ($urandom_range(0, 3) == 0));
                    end
                    default:    header = {16'($urandom), types[$urandom_range(0, 4)]};
                endcase
            end else begin
                packet_valid = 0;
            end
            cycle();
        end
        packet_valid = 0; reset = 0; audio_ready = 1;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
